// File: rtl/exu_pkg.sv
// Shared definitions for the execute-unit write-back path: default widths and
// the encoding that tells the regfile which producer owns the current write.
package exu_pkg;

    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned RF_AW_DEF      = 5;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned STARVE_CNT_W   = 4;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_LSU  = 2'd1,
        WB_SRC_MDU  = 2'd2,
        WB_SRC_ALU  = 2'd3
    } wb_src_e;

    // A destination of x0 consumes the write slot but never reaches the regfile.
    function automatic logic rf_write_effective(input logic wen, input logic rd_is_zero);
        return wen & ~rd_is_zero;
    endfunction

endpackage

// File: rtl/exu_wbck_starve.sv
// Per-requester starvation tracker: counts consecutive lost cycles and raises
// boost once the count reaches STARVE_MAX, until the requester wins or drops.
module exu_wbck_starve
    import exu_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    input  logic ready_i,
    output logic boost_o
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (!valid_i || ready_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign boost_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/exu_wbck_arb.sv
// Register-file write-back arbiter: picks one of LSU / MDU / ALU results per
// cycle and registers the winning write into a single output stage.
module exu_wbck_arb
    import exu_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned RF_AW      = RF_AW_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             i_lsu_valid,
    output logic             o_lsu_ready,
    input  logic             i_lsu_wen,
    input  logic [RF_AW-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]  i_lsu_data,

    input  logic             i_mdu_valid,
    output logic             o_mdu_ready,
    input  logic             i_mdu_wen,
    input  logic [RF_AW-1:0] i_mdu_rd,
    input  logic [XLEN-1:0]  i_mdu_data,

    input  logic             i_alu_valid,
    output logic             o_alu_ready,
    input  logic             i_alu_wen,
    input  logic [RF_AW-1:0] i_alu_rd,
    input  logic [XLEN-1:0]  i_alu_data,

    output logic             o_rf_wen,
    output logic [RF_AW-1:0] o_rf_waddr,
    output logic [XLEN-1:0]  o_rf_wdata,
    output logic [1:0]       o_wb_src
);

    logic mdu_boost;
    logic alu_boost;

    wb_src_e          grant_src;
    logic             grant_wen;
    logic [RF_AW-1:0] grant_rd;
    logic [XLEN-1:0]  grant_data;

    logic             rf_wen_q,   rf_wen_d;
    logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    wb_src_e          wb_src_q,   wb_src_d;

    exu_wbck_starve #(.STARVE_MAX(STARVE_MAX)) u_mdu_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (i_mdu_valid),
        .ready_i (o_mdu_ready),
        .boost_o (mdu_boost)
    );

    exu_wbck_starve #(.STARVE_MAX(STARVE_MAX)) u_alu_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (i_alu_valid),
        .ready_i (o_alu_ready),
        .boost_o (alu_boost)
    );

    // Boost is qualified by the current valid: the counter only clears a cycle
    // after valid drops, and an idle requester must never be granted.
    always_comb begin
        grant_src = WB_SRC_NONE;
        if (i_alu_valid && alu_boost) begin
            grant_src = WB_SRC_ALU;
        end else if (i_mdu_valid && mdu_boost) begin
            grant_src = WB_SRC_MDU;
        end else if (i_lsu_valid) begin
            grant_src = WB_SRC_LSU;
        end else if (i_mdu_valid) begin
            grant_src = WB_SRC_MDU;
        end else if (i_alu_valid) begin
            grant_src = WB_SRC_ALU;
        end
    end

    assign o_lsu_ready = (grant_src == WB_SRC_LSU);
    assign o_mdu_ready = (grant_src == WB_SRC_MDU);
    assign o_alu_ready = (grant_src == WB_SRC_ALU);

    always_comb begin
        grant_wen  = 1'b0;
        grant_rd   = '0;
        grant_data = '0;
        unique case (grant_src)
            WB_SRC_LSU: begin
                grant_wen  = i_lsu_wen;
                grant_rd   = i_lsu_rd;
                grant_data = i_lsu_data;
            end
            WB_SRC_MDU: begin
                grant_wen  = i_mdu_wen;
                grant_rd   = i_mdu_rd;
                grant_data = i_mdu_data;
            end
            WB_SRC_ALU: begin
                grant_wen  = i_alu_wen;
                grant_rd   = i_alu_rd;
                grant_data = i_alu_data;
            end
            default: ;
        endcase
    end

    // Address and data keep their last value across idle cycles.
    always_comb begin
        wb_src_d   = grant_src;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_src != WB_SRC_NONE) begin
            rf_wen_d   = rf_write_effective(grant_wen, grant_rd == '0);
            rf_waddr_d = grant_rd;
            rf_wdata_d = grant_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_src_q   <= WB_SRC_NONE;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_src_q   <= wb_src_d;
        end
    end

    assign o_rf_wen   = rf_wen_q;
    assign o_rf_waddr = rf_waddr_q;
    assign o_rf_wdata = rf_wdata_q;
    assign o_wb_src   = wb_src_q;

endmodule

// File: tb/tb_exu_wbck_arb.sv
// Randomized bench for exu_wbck_arb: a behavioural arbitration model pushes
// expected writes into a queue that an independent output monitor drains.
module tb_exu_wbck_arb;

    localparam int XLEN  = 32;
    localparam int RF_AW = 5;
    localparam int SM    = 4;

    logic             clk;
    logic             rst_n;
    logic             i_lsu_valid, i_lsu_wen, o_lsu_ready;
    logic [RF_AW-1:0] i_lsu_rd;
    logic [XLEN-1:0]  i_lsu_data;
    logic             i_mdu_valid, i_mdu_wen, o_mdu_ready;
    logic [RF_AW-1:0] i_mdu_rd;
    logic [XLEN-1:0]  i_mdu_data;
    logic             i_alu_valid, i_alu_wen, o_alu_ready;
    logic [RF_AW-1:0] i_alu_rd;
    logic [XLEN-1:0]  i_alu_data;
    logic             o_rf_wen;
    logic [RF_AW-1:0] o_rf_waddr;
    logic [XLEN-1:0]  o_rf_wdata;
    logic [1:0]       o_wb_src;

    exu_wbck_arb #(.XLEN(XLEN), .RF_AW(RF_AW), .STARVE_MAX(SM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_lsu_valid (i_lsu_valid),
        .o_lsu_ready (o_lsu_ready),
        .i_lsu_wen   (i_lsu_wen),
        .i_lsu_rd    (i_lsu_rd),
        .i_lsu_data  (i_lsu_data),
        .i_mdu_valid (i_mdu_valid),
        .o_mdu_ready (o_mdu_ready),
        .i_mdu_wen   (i_mdu_wen),
        .i_mdu_rd    (i_mdu_rd),
        .i_mdu_data  (i_mdu_data),
        .i_alu_valid (i_alu_valid),
        .o_alu_ready (o_alu_ready),
        .i_alu_wen   (i_alu_wen),
        .i_alu_rd    (i_alu_rd),
        .i_alu_data  (i_alu_data),
        .o_rf_wen    (o_rf_wen),
        .o_rf_waddr  (o_rf_waddr),
        .o_rf_wdata  (o_rf_wdata),
        .o_wb_src    (o_wb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       src;
        logic             wen;
        logic [RF_AW-1:0] addr;
        logic [XLEN-1:0]  data;
    } wb_t;

    wb_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Requester index: 0 = LSU, 1 = MDU, 2 = ALU (write-back source code = index + 1).
    logic             req_v    [3];
    logic             req_wen  [3];
    logic [RF_AW-1:0] req_rd   [3];
    logic [XLEN-1:0]  req_data [3];

    int               lost [3];
    logic [RF_AW-1:0] hold_addr;
    logic [XLEN-1:0]  hold_data;
    logic             mon_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive();
        i_lsu_valid = req_v[0]; i_lsu_wen = req_wen[0]; i_lsu_rd = req_rd[0]; i_lsu_data = req_data[0];
        i_mdu_valid = req_v[1]; i_mdu_wen = req_wen[1]; i_mdu_rd = req_rd[1]; i_mdu_data = req_data[1];
        i_alu_valid = req_v[2]; i_alu_wen = req_wen[2]; i_alu_rd = req_rd[2]; i_alu_data = req_data[2];
    endtask

    task automatic set_req(input int r, input logic v, input logic wen, input int rd, input logic [XLEN-1:0] data);
        req_v[r]    = v;
        req_wen[r]  = wen;
        req_rd[r]   = RF_AW'(rd);
        req_data[r] = data;
    endtask

    // New random request with probability pct; rd=0 appears about 1 time in 8.
    task automatic refill(input int r, input int pct);
        req_v[r]    = ($urandom_range(0, 99) < pct);
        req_wen[r]  = ($urandom_range(0, 3) != 0);
        req_rd[r]   = ($urandom_range(0, 7) == 0) ? '0 : RF_AW'($urandom_range(1, 31));
        req_data[r] = $urandom;
    endtask

    // Arbitration from the rules: a requester that has lost SM cycles in a row
    // goes first (ALU ahead of MDU), otherwise LSU > MDU > ALU.
    task automatic model_step(output int win);
        wb_t e;
        win = -1;
        if (req_v[2] && lost[2] >= SM)      win = 2;
        else if (req_v[1] && lost[1] >= SM) win = 1;
        else begin
            for (int r = 0; r < 3; r++) begin
                if (win < 0 && req_v[r]) win = r;
            end
        end
        check("lsu_ready", {63'd0, o_lsu_ready}, {63'd0, win == 0});
        check("mdu_ready", {63'd0, o_mdu_ready}, {63'd0, win == 1});
        check("alu_ready", {63'd0, o_alu_ready}, {63'd0, win == 2});
        for (int r = 1; r < 3; r++) begin
            if (req_v[r] && win != r) lost[r] = (lost[r] + 1 > SM) ? SM : lost[r] + 1;
            else lost[r] = 0;
        end
        if (win >= 0) begin
            e.src  = 2'(win + 1);
            e.wen  = req_wen[win] && (req_rd[win] != 0);
            e.addr = req_rd[win];
            e.data = req_data[win];
            exp_q.push_back(e);
        end
    endtask

    task automatic step(output int win);
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        model_step(win);
    endtask

    // Output monitor: every registered write must match the oldest expectation;
    // idle cycles must show no write and held address/data.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (o_wb_src != 2'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_src", {62'd0, o_wb_src}, 64'd0);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    check("wb_src",   {62'd0, o_wb_src}, {62'd0, e.src});
                    check("rf_wen",   {63'd0, o_rf_wen}, {63'd0, e.wen});
                    check("rf_waddr", 64'(o_rf_waddr),   64'(e.addr));
                    check("rf_wdata", 64'(o_rf_wdata),   64'(e.data));
                    hold_addr = e.addr;
                    hold_data = e.data;
                end
            end else begin
                check("idle_wen",   {63'd0, o_rf_wen}, 64'd0);
                check("idle_waddr", 64'(o_rf_waddr),   64'(hold_addr));
                check("idle_wdata", 64'(o_rf_wdata),   64'(hold_data));
            end
        end
    end

    initial begin
        int win;
        int alu_wins;
        int since [3];
        int max_gap [3];

        mon_en    = 1'b0;
        rst_n     = 1'b0;
        hold_addr = '0;
        hold_data = '0;
        for (int r = 0; r < 3; r++) begin
            set_req(r, 1'b0, 1'b0, 0, '0);
            lost[r] = 0;
        end
        drive();

        repeat (3) @(posedge clk);
        #1;
        check("rst_rf_wen",   {63'd0, o_rf_wen}, 64'd0);
        check("rst_waddr",    64'(o_rf_waddr),   64'd0);
        check("rst_wdata",    64'(o_rf_wdata),   64'd0);
        check("rst_wb_src",   {62'd0, o_wb_src}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Idle after reset
        repeat (10) step(win);

        // Single ALU write
        set_req(2, 1'b1, 1'b1, 5, 32'h1234_5678);
        step(win);
        check("alu_single_grant", 64'(win), 64'd2);
        req_v[2] = 1'b0;
        step(win);
        check("alu_single_wen",   {63'd0, o_rf_wen}, 64'd1);
        check("alu_single_waddr", 64'(o_rf_waddr),   64'd5);
        check("alu_single_wdata", 64'(o_rf_wdata),   64'h1234_5678);
        check("alu_single_src",   {62'd0, o_wb_src}, 64'd3);

        // Fixed priority, each requester drops after its handshake
        set_req(0, 1'b1, 1'b1, 1, 32'hA);
        set_req(1, 1'b1, 1'b1, 2, 32'hB);
        set_req(2, 1'b1, 1'b1, 3, 32'hC);
        for (int i = 0; i < 3; i++) begin
            step(win);
            check("prio_order", 64'(win), 64'(i));
            if (win >= 0) req_v[win] = 1'b0;
        end
        repeat (2) step(win);

        // Starvation boost: LSU and ALU always valid, fresh payload after each handshake
        refill(0, 100);
        refill(2, 100);
        for (int i = 0; i < 15; i++) begin
            step(win);
            check("starve_pattern", 64'(win), (i % 5 == 4) ? 64'd2 : 64'd0);
            if (win >= 0) refill(win, 100);
        end
        req_v[0] = 1'b0;
        req_v[2] = 1'b0;
        repeat (2) step(win);

        // x0 destination: slot consumed, write suppressed, source still reported
        set_req(1, 1'b1, 1'b1, 0, 32'hFFFF_FFFF);
        step(win);
        check("x0_grant", 64'(win), 64'd1);
        req_v[1] = 1'b0;
        step(win);
        check("x0_wen",   {63'd0, o_rf_wen}, 64'd0);
        check("x0_src",   {62'd0, o_wb_src}, 64'd2);
        check("x0_wdata", 64'(o_rf_wdata),   64'hFFFF_FFFF);
        step(win);

        // Async reset while an ALU boost is pending and a write is on the port
        set_req(0, 1'b1, 1'b1, 7, 32'h0000_0777);
        set_req(2, 1'b1, 1'b1, 9, 32'h0000_0999);
        for (int i = 0; i < SM; i++) begin
            step(win);
            check("pre_reset_lsu_win", 64'(win), 64'd0);
        end
        @(posedge clk);
        #1;
        drive();
        check("pre_reset_wen",   {63'd0, o_rf_wen},    64'd1);
        check("pre_reset_boost", {63'd0, o_alu_ready}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_wen_drop",  {63'd0, o_rf_wen},    64'd0);
        check("reset_src_drop",  {62'd0, o_wb_src},    64'd0);
        check("reset_boost_clr", {63'd0, o_alu_ready}, 64'd0);
        exp_q.delete();
        for (int r = 0; r < 3; r++) lost[r] = 0;
        hold_addr = '0;
        hold_data = '0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        model_step(win);
        alu_wins = (win == 2) ? 1 : 0;
        for (int i = 0; i < SM; i++) begin
            step(win);
            if (win == 2) alu_wins++;
        end
        check("post_reset_alu_wait", 64'(win),      64'd2);
        check("post_reset_alu_once", 64'(alu_wins), 64'd1);
        req_v[0] = 1'b0;
        req_v[2] = 1'b0;
        repeat (2) step(win);

        // Random traffic
        for (int r = 0; r < 3; r++) refill(r, 60);
        for (int i = 0; i < 400; i++) begin
            step(win);
            for (int r = 0; r < 3; r++) begin
                if (!req_v[r] || win == r) refill(r, 60);
            end
        end

        // All three permanently valid: every requester served within SM+2 cycles
        for (int r = 0; r < 3; r++) begin
            if (!req_v[r]) refill(r, 100);
            since[r]   = 0;
            max_gap[r] = 0;
        end
        for (int i = 0; i < 40; i++) begin
            step(win);
            for (int r = 0; r < 3; r++) begin
                since[r]++;
                if (win == r) begin
                    if (i >= 10 && since[r] > max_gap[r]) max_gap[r] = since[r];
                    since[r] = 0;
                end
            end
            if (win >= 0) refill(win, 100);
        end
        for (int r = 0; r < 3; r++) begin
            check("service_gap_ok", 64'(max_gap[r] >= 1 && max_gap[r] <= SM + 2), 64'd1);
        end

        // Drain
        for (int r = 0; r < 3; r++) req_v[r] = 1'b0;
        repeat (3) step(win);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exu_wbck_arb.md
Name: exu_wbck_arb

Overview:
- Register-file write-back arbiter for the execute unit.
- Shares the single RF write port between three result producers:
  - the single-cycle ALU result path;
  - the load return path from the LSU;
  - the multi-cycle multiply/divide unit (MDU).
- Uses fixed priority with per-requester anti-starvation boost, and registers the winning write into a one-stage output pipeline feeding the regfile.

Parameters:
- XLEN, 32, data width of write-back values
- RF_AW, 5, register address width
- STARVE_MAX, 4, consecutive lost cycles before a low-priority requester is boosted (range 1..15)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_lsu_valid  in  1  LSU load result valid
- o_lsu_ready  out  1  LSU result accepted this cycle
- i_lsu_wen  in  1  LSU result writes RF
- i_lsu_rd  in  RF_AW  LSU destination register
- i_lsu_data  in  XLEN  LSU load data
- i_mdu_valid  in  1  MDU result valid
- o_mdu_ready  out  1  MDU result accepted
- i_mdu_wen  in  1  MDU writes RF
- i_mdu_rd  in  RF_AW  MDU destination
- i_mdu_data  in  XLEN  MDU result
- i_alu_valid  in  1  ALU result valid
- o_alu_ready  out  1  ALU result accepted
- i_alu_wen  in  1  ALU writes RF
- i_alu_rd  in  RF_AW  ALU destination
- i_alu_data  in  XLEN  ALU result
- o_rf_wen  out  1  RF write enable (registered)
- o_rf_waddr  out  RF_AW  RF write address (registered)
- o_rf_wdata  out  XLEN  RF write data (registered)
- o_wb_src  out  2  source of current o_rf write: 0 none, 1 LSU, 2 MDU, 3 ALU (registered)

Behaviour:
- Reset values:
  - o_rf_wen=0, o_rf_waddr=0, o_rf_wdata=0, o_wb_src=0.
  - Both starvation counters 0, both boost flags 0.
- Grant is combinational; exactly one grant at most per cycle. ready = grant; handshake = valid & ready.
- Readys never depend on their own valid beyond the grant; a requester that is not valid is never granted.
- Priority, highest first: ALU-boosted > MDU-boosted > LSU > MDU > ALU.
- Starvation counter per requester (MDU, ALU), 4 bits:
  - Increments when valid & !ready.
  - Saturates at STARVE_MAX.
  - Clears to 0 on that requester's handshake, or when its valid is low.
  - boost = (counter == STARVE_MAX).
- The LSU cannot starve: a boost requires STARVE_MAX lost cycles, and each boost is consumed by one grant.
- Latency: a handshake in cycle N produces o_rf_* in cycle N+1, held for exactly one cycle.
- o_rf_wen computation:
  - o_rf_wen = granted wen & (granted rd != 0). Writes to x0 consume the slot but drive o_rf_wen=0.
  - o_wb_src still shows the source of a granted write whose o_rf_wen is suppressed.
  - o_rf_waddr/o_rf_wdata take the granted values even when o_rf_wen=0.
- No grant in cycle N: in N+1, o_rf_wen=0 and o_wb_src=0; o_rf_waddr/o_rf_wdata hold their previous values.
- Payload stability: requesters hold their payload stable while valid & !ready. The block does not check this.
- Reset asserted mid-operation: outputs and counters clear immediately. Pending requests are simply re-arbitrated after reset release; nothing is lost inside the block, because no request is held internally.
- All three requesters valid every cycle, STARVE_MAX=4: the grant sequence is periodic and each requester is granted at least once per STARVE_MAX+2 cycles.

Decomposition:
- Shared package exu_pkg holds:
  - the WB_SRC_NONE/LSU/MDU/ALU encodings (2-bit);
  - the XLEN and RF_AW defaults.
- One sub-module is natural: exu_wbck_starve, instantiated twice. It contains the saturating counter and boost flag, with inputs valid/ready and output boost.
- The arbiter priority mux and the output register stay in the top module.

Test Plan:
- Reset/idle: hold rst_n=0 then release, no valids → o_rf_wen=0, o_wb_src=0, all readys 0 for 10 cycles.
- Single ALU write: i_alu_valid=1, rd=5, data=0x1234_5678, wen=1, for one cycle → o_alu_ready=1 same cycle; next cycle o_rf_wen=1, o_rf_waddr=5, o_rf_wdata=0x12345678, o_wb_src=3.
- Fixed priority: LSU (rd=1, 0xA), MDU (rd=2, 0xB), ALU (rd=3, 0xC) valid together, each dropping valid after its handshake → writes appear on consecutive cycles in the order rd=1, rd=2, rd=3.
- Starvation boost, STARVE_MAX=4: LSU and ALU valid continuously with new payloads → LSU granted cycles 0–3, ALU granted cycle 4, counter clears, pattern repeats with period 5.
- x0 suppression: MDU valid with rd=0, wen=1, data=0xFFFF_FFFF → o_mdu_ready=1; next cycle o_rf_wen=0, o_wb_src=2, o_rf_wdata=0xFFFFFFFF.
- Async reset mid-stream: assert rst_n=0 for half a cycle while an ALU boost is pending and o_rf_wen=1 → o_rf_wen drops immediately and the counters read 0. After release, the ALU needs 4 more lost cycles before it is boosted again.
